sid_voice_mixer: RTL and testbench

SID_VOICE_MIXER -- requirements
Module: sid_voice_mixer

---
 rtl/sid_voice_mixer.sv | 142 ++++++++++++++
 tb/tb_sid_voice_mixer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_mixer.sv
// sid_voice_mixer
// Sums three SID voices and an external input into a 14-bit signed accumulator. It then
// scales the sum by the 4-bit master volume and presents it as a signed 16-bit sample.
// A mix is requested by ce_1m and runs through a fixed 7-state sequence, one state per clock.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   ce_1m        one-clock mix request strobe
//   voice1..3    signed 12-bit voice samples
//   ext_in       signed 12-bit external audio
//   mode_vol     bit7 mutes voice 3, bits3:0 master volume
//   peak_clr     clears peak
//   overrun_clr  clears overrun
//   audio_out    signed 16-bit mixed sample, held between updates
//   sample_valid one-cycle pulse when audio_out updates
//   peak         largest |audio_out| since last clear
//   overrun      sticky: a request arrived while a mix was running
//   busy         high whenever the sequencer is not idle
module sid_voice_mixer (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce_1m,
    input  logic signed [11:0] voice1,
    input  logic signed [11:0] voice2,
    input  logic signed [11:0] voice3,
    input  logic signed [11:0] ext_in,
    input  logic        [7:0]  mode_vol,
    input  logic               peak_clr,
    input  logic               overrun_clr,
    output logic signed [15:0] audio_out,
    output logic               sample_valid,
    output logic        [14:0] peak,
    output logic               overrun,
    output logic               busy
);

    typedef enum logic [2:0] {
        StIdle,
        StSum1,
        StSum2,
        StSum3,
        StSum4,
        StScale,
        StOut
    } state_t;

    state_t             state;
    logic signed [11:0] v1_s, v2_s, v3_s, ext_s;
    logic        [7:0]  mode_s;
    logic signed [13:0] acc;
    logic signed [17:0] prod;

    logic signed [17:0] prod_next;
    logic signed [15:0] out_new;
    logic        [14:0] out_mag;
    logic               unused_bits;

    function automatic logic signed [13:0] sx(input logic signed [11:0] v);
        return {{2{v[11]}}, v};
    endfunction

    // Volume is unsigned, so it enters the multiply as a non-negative signed operand.
    assign prod_next = $signed({{4{acc[13]}}, acc}) * $signed({14'd0, mode_s[3:0]});

    // Dropping the two LSBs of a two's-complement value is a floor divide by 4.
    assign out_new = prod[17:2];

    // |out_new| never exceeds 30720, so 15 bits are enough.
    assign out_mag = out_new[15] ? 15'(-out_new) : out_new[14:0];

    assign busy = (state != StIdle);

    assign unused_bits = ^{mode_s[6:4], prod[1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            v1_s         <= '0;
            v2_s         <= '0;
            v3_s         <= '0;
            ext_s        <= '0;
            mode_s       <= '0;
            acc          <= '0;
            prod         <= '0;
            audio_out    <= '0;
            sample_valid <= 1'b0;
            peak         <= '0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (overrun_clr) overrun <= 1'b0;
            if (peak_clr) peak <= '0;

            case (state)
                StIdle: begin
                    if (ce_1m) begin
                        v1_s   <= voice1;
                        v2_s   <= voice2;
                        v3_s   <= voice3;
                        ext_s  <= ext_in;
                        mode_s <= mode_vol;
                        acc    <= '0;
                        state  <= StSum1;
                    end
                end
                StSum1: begin
                    acc   <= acc + sx(v1_s);
                    state <= StSum2;
                end
                StSum2: begin
                    acc   <= acc + sx(v2_s);
                    state <= StSum3;
                end
                StSum3: begin
                    acc   <= acc + (mode_s[7] ? 14'sd0 : sx(v3_s));
                    state <= StSum4;
                end
                StSum4: begin
                    acc   <= acc + sx(ext_s);
                    state <= StScale;
                end
                StScale: begin
                    prod  <= prod_next;
                    state <= StOut;
                end
                StOut: begin
                    audio_out    <= out_new;
                    sample_valid <= 1'b1;
                    // A clear in the same cycle restarts tracking from this sample.
                    if (peak_clr || (out_mag > peak)) peak <= out_mag;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase

            // Requests during a mix are dropped; the flag set beats a same-cycle clear.
            if (ce_1m && (state != StIdle)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Directed self-checking bench for sid_voice_mixer.
module tb_sid_voice_mixer;

    logic               clock = 1'b0;
    logic               reset;
    logic               ce_1m;
    logic signed [11:0] voice1, voice2, voice3, ext_in;
    logic        [7:0]  mode_vol;
    logic               peak_clr, overrun_clr;
    logic signed [15:0] audio_out;
    logic               sample_valid;
    logic        [14:0] peak;
    logic               overrun;
    logic               busy;

    int tests_run    = 0;
    int tests_failed = 0;

    sid_voice_mixer dut (
        .clock       (clock),
        .reset       (reset),
        .ce_1m       (ce_1m),
        .voice1      (voice1),
        .voice2      (voice2),
        .voice3      (voice3),
        .ext_in      (ext_in),
        .mode_vol    (mode_vol),
        .peak_clr    (peak_clr),
        .overrun_clr (overrun_clr),
        .audio_out   (audio_out),
        .sample_valid(sample_valid),
        .peak        (peak),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_inputs(input int a, input int b, input int c, input int e,
                              input logic [7:0] mv);
        voice1   = 12'(a);
        voice2   = 12'(b);
        voice3   = 12'(c);
        ext_in   = 12'(e);
        mode_vol = mv;
    endtask

    // Issue one request and wait (bounded) for its sample; lat = -1 if none arrives.
    task automatic do_mix(input int a, input int b, input int c, input int e,
                          input logic [7:0] mv, output logic signed [15:0] res,
                          output int lat);
        set_inputs(a, b, c, e, mv);
        ce_1m = 1'b1;
        cyc();
        ce_1m = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (sample_valid) begin
                lat = k;
                break;
            end
        end
        res = audio_out;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ce_1m = 1'b0;
        peak_clr = 1'b0;
        overrun_clr = 1'b0;
        set_inputs(0, 0, 0, 0, 8'h00);
        cyc();
        cyc();
        tests_run++;
        if ({audio_out, sample_valid, peak, overrun, busy} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got out=%0d sv=%0b peak=%0d ovr=%0b busy=%0b want all 0",
                     audio_out, sample_valid, peak, overrun, busy);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic signed [15:0] res;
        int lat;
        do_mix(100, 200, 300, 0, 8'h0F, res, lat);
        tests_run++;
        if (lat !== 6) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d want 6", lat);
        end
        tests_run++;
        if (res !== 16'sd2250) begin
            tests_failed++;
            $display("FAIL basic_out: got %0d want 2250", res);
        end
        tests_run++;
        if (peak !== 15'd2250) begin
            tests_failed++;
            $display("FAIL basic_peak: got %0d want 2250", peak);
        end
        cyc();
        tests_run++;
        if (sample_valid !== 1'b0 || audio_out !== 16'sd2250 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_hold: got sv=%0b out=%0d busy=%0b want sv=0 out=2250 busy=0",
                     sample_valid, audio_out, busy);
        end
    endtask

    task automatic test_volume();
        logic signed [15:0] res;
        int lat;
        // Voice 3 muted: (100+200)*15 >> 2 = 1125.
        do_mix(100, 200, 300, 0, 8'h8F, res, lat);
        tests_run++;
        if (res !== 16'sd1125 || lat !== 6) begin
            tests_failed++;
            $display("FAIL mute_v3: got out=%0d lat=%0d want out=1125 lat=6", res, lat);
        end
        do_mix(100, 200, 300, 0, 8'h00, res, lat);
        tests_run++;
        if (res !== 16'sd0 || lat !== 6) begin
            tests_failed++;
            $display("FAIL vol_zero: got out=%0d lat=%0d want out=0 lat=6", res, lat);
        end
        tests_run++;
        if (peak !== 15'd2250) begin
            tests_failed++;
            $display("FAIL vol_peak_kept: got %0d want 2250", peak);
        end
        // Bits 6:4 are ignored: (10+20+30+40)*15 >> 2 = 375.
        do_mix(10, 20, 30, 40, 8'h7F, res, lat);
        tests_run++;
        if (res !== 16'sd375) begin
            tests_failed++;
            $display("FAIL ext_and_ignored_bits: got %0d want 375", res);
        end
    endtask

    task automatic test_extremes();
        logic signed [15:0] res;
        int lat;
        do_mix(-2048, -2048, -2048, -2048, 8'h0F, res, lat);
        tests_run++;
        if (res !== -16'sd30720 || peak !== 15'd30720) begin
            tests_failed++;
            $display("FAIL neg_full: got out=%0d peak=%0d want out=-30720 peak=30720", res, peak);
        end
        // 4*15 = 60 >> 2 = 15.
        do_mix(1, 1, 1, 1, 8'h0F, res, lat);
        tests_run++;
        if (res !== 16'sd15) begin
            tests_failed++;
            $display("FAIL ones_vol15: got %0d want 15", res);
        end
        // 4*3 = 12 >> 2 = 3.
        do_mix(1, 1, 1, 1, 8'h03, res, lat);
        tests_run++;
        if (res !== 16'sd3 || peak !== 15'd30720) begin
            tests_failed++;
            $display("FAIL ones_vol3: got out=%0d peak=%0d want out=3 peak=30720", res, peak);
        end
        // Floor rounding: -3*3 = -9 >> 2 = -3.
        do_mix(-3, 0, 0, 0, 8'h03, res, lat);
        tests_run++;
        if (res !== -16'sd3) begin
            tests_failed++;
            $display("FAIL floor_round: got %0d want -3", res);
        end
    endtask

    task automatic test_overrun();
        int nvalid = 0;
        int vat = -1;
        logic signed [15:0] vout = '0;
        set_inputs(100, 200, 300, 0, 8'h0F);
        ce_1m = 1'b1;
        cyc();                              // T
        ce_1m = 1'b0;
        set_inputs(1, 1, 1, 1, 8'h01);      // changed after capture
        cyc();                              // T+1
        cyc();                              // T+2
        ce_1m = 1'b1;
        cyc();                              // T+3, ignored request
        ce_1m = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_mid_mix: got %0b want 1", busy);
        end
        for (int k = 4; k <= 14; k++) begin
            cyc();
            if (sample_valid) begin
                nvalid++;
                vat  = k;
                vout = audio_out;
            end
        end
        tests_run++;
        if (nvalid !== 1 || vat !== 6 || vout !== 16'sd2250) begin
            tests_failed++;
            $display("FAIL overrun_single_sample: got n=%0d at=%0d out=%0d want n=1 at=6 out=2250",
                     nvalid, vat, vout);
        end
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got %0b want 1", overrun);
        end
        // Set and clear in the same cycle: set wins.
        ce_1m = 1'b1;
        cyc();
        ce_1m = 1'b1;
        overrun_clr = 1'b1;
        cyc();
        ce_1m = 1'b0;
        overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set_wins: got %0b want 1", overrun);
        end
        for (int k = 0; k < 8; k++) cyc();
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clr: got %0b want 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] res1, res2;
        int lat1, lat2;
        do_mix(100, 200, 300, 0, 8'h0F, res1, lat1);
        // Request lands in the idle cycle right after OUT: 7-clock spacing.
        do_mix(10, 20, 30, 40, 8'h0F, res2, lat2);
        tests_run++;
        if (lat1 !== 6 || lat2 !== 6 || res1 !== 16'sd2250 || res2 !== 16'sd375) begin
            tests_failed++;
            $display("FAIL back_to_back: got lat=%0d/%0d out=%0d/%0d want lat=6/6 out=2250/375",
                     lat1, lat2, res1, res2);
        end
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back_no_overrun: got %0b want 0", overrun);
        end
    endtask

    task automatic test_peak_clr();
        set_inputs(-2, 0, 0, 0, 8'h09);     // -2*9 = -18 >> 2 = -5
        ce_1m = 1'b1;
        cyc();                              // T
        ce_1m = 1'b0;
        for (int k = 1; k <= 5; k++) cyc(); // T+5: state is OUT
        peak_clr = 1'b1;
        cyc();                              // T+6
        peak_clr = 1'b0;
        tests_run++;
        if (sample_valid !== 1'b1 || audio_out !== -16'sd5 || peak !== 15'd5) begin
            tests_failed++;
            $display("FAIL peak_clr_at_out: got sv=%0b out=%0d peak=%0d want sv=1 out=-5 peak=5",
                     sample_valid, audio_out, peak);
        end
        peak_clr = 1'b1;
        cyc();
        peak_clr = 1'b0;
        tests_run++;
        if (peak !== 15'd0) begin
            tests_failed++;
            $display("FAIL peak_clr_idle: got %0d want 0", peak);
        end
    endtask

    task automatic test_reset_abort();
        logic signed [15:0] res;
        int lat;
        int nvalid = 0;
        set_inputs(100, 200, 300, 0, 8'h0F);
        ce_1m = 1'b1;
        cyc();                              // T
        ce_1m = 1'b0;
        for (int k = 1; k <= 3; k++) cyc(); // T+3
        reset = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || audio_out !== 16'sd0) begin
            tests_failed++;
            $display("FAIL reset_async: got busy=%0b out=%0d want busy=0 out=0", busy, audio_out);
        end
        cyc();
        if (sample_valid) nvalid++;
        cyc();                              // T+5
        if (sample_valid) nvalid++;
        reset = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            cyc();
            if (sample_valid) nvalid++;
        end
        tests_run++;
        if (nvalid !== 0 || {audio_out, peak, overrun, busy} !== 33'd0) begin
            tests_failed++;
            $display("FAIL reset_abort: got n=%0d out=%0d peak=%0d ovr=%0b busy=%0b want all 0",
                     nvalid, audio_out, peak, overrun, busy);
        end
        do_mix(100, 200, 300, 0, 8'h0F, res, lat);  // request sampled at T+10
        tests_run++;
        if (lat !== 6 || res !== 16'sd2250) begin
            tests_failed++;
            $display("FAIL after_reset_mix: got lat=%0d out=%0d want lat=6 out=2250", lat, res);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_volume();
        test_extremes();
        test_overrun();
        test_back_to_back();
        test_peak_clr();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
